// File: rtl/refund_dispenser.sv
// Payout controller: pulses one product motor, then pays change coin by coin from the hopper.
// Build option: define REFUND_DISPENSER_COIN5_EN to enable the 5-unit tube (otherwise 1-unit only).
module refund_dispenser #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] refund,
  input  logic [3:0] push,
  input  logic       coin_sense,
  input  logic       empty5,
  input  logic       empty1,
  output logic [3:0] vend_motor,
  output logic       eject5,
  output logic       eject1,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] owed
);

  localparam int unsigned AMT_W  = 4;
  localparam int unsigned PCNT_W = 4;
  localparam int unsigned TCNT_W = 8;
  localparam logic [PCNT_W-1:0] PULSE_LAST   = PCNT_W'(PULSE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VEND  = 3'd1,
    S_SEL   = 3'd2,
    S_EJECT = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [3:0]          prod_q, prod_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                hit_q, hit_d;
  logic                coin_q;
  logic                coin_edge_c;
  logic [AMT_W-1:0]    step_amt_c;

  logic [3:0]          vend_motor_q, vend_motor_d;
  logic                eject1_q, eject1_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;

  assign coin_edge_c = coin_sense & ~coin_q;

`ifdef REFUND_DISPENSER_COIN5_EN
  logic den5_q, den5_d;
  logic eject5_q, eject5_d;
  assign step_amt_c = den5_q ? AMT_W'(5) : AMT_W'(1);
  assign eject5     = eject5_q;
`else
  logic unused_empty5;
  assign unused_empty5 = empty5;
  assign step_amt_c    = AMT_W'(1);
  assign eject5        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath updates
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    hit_d   = hit_q;
`ifdef REFUND_DISPENSER_COIN5_EN
    den5_d  = den5_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = refund;
          prod_d  = push;
          pcnt_d  = '0;
          state_d = (push != 4'd0) ? S_VEND : S_SEL;
        end
      end
      S_VEND: begin
        if (pcnt_q == PULSE_LAST) begin
          pcnt_d  = '0;
          state_d = S_SEL;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      S_SEL: begin
        pcnt_d = '0;
        hit_d  = 1'b0;
        if (rem_q == '0) begin
          state_d = S_DONE;
`ifdef REFUND_DISPENSER_COIN5_EN
        end else if ((rem_q >= AMT_W'(5)) && !empty5) begin
          den5_d  = 1'b1;
          state_d = S_EJECT;
`endif
        end else if (!empty1) begin
`ifdef REFUND_DISPENSER_COIN5_EN
          den5_d  = 1'b0;
`endif
          state_d = S_EJECT;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_EJECT: begin
        // Only the first sensor edge of an eject pays down the balance
        if (coin_edge_c && !hit_q) begin
          rem_d = rem_q - step_amt_c;
          hit_d = 1'b1;
        end
        if (pcnt_q == PULSE_LAST) begin
          pcnt_d  = '0;
          tcnt_d  = '0;
          state_d = (hit_q || coin_edge_c) ? S_SEL : S_WAIT;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (coin_edge_c) begin
          rem_d   = rem_q - step_amt_c;
          state_d = S_SEL;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d = S_FAULT;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    vend_motor_d = '0;
    eject1_d     = 1'b0;
`ifdef REFUND_DISPENSER_COIN5_EN
    eject5_d     = 1'b0;
`endif
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    fault_d      = fault_q;
    if (state_d == S_VEND) vend_motor_d = prod_d;
    if (state_d == S_EJECT) begin
`ifdef REFUND_DISPENSER_COIN5_EN
      if (den5_d) eject5_d = 1'b1;
      else        eject1_d = 1'b1;
`else
      eject1_d = 1'b1;
`endif
    end
    if ((state_q == S_IDLE) && start) fault_d = 1'b0;
    if (state_d == S_FAULT)           fault_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q        <= '0;
      prod_q       <= '0;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      hit_q        <= 1'b0;
      coin_q       <= 1'b0;
      vend_motor_q <= '0;
      eject1_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
`ifdef REFUND_DISPENSER_COIN5_EN
      den5_q       <= 1'b0;
      eject5_q     <= 1'b0;
`endif
    end else begin
      rem_q        <= rem_d;
      prod_q       <= prod_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      hit_q        <= hit_d;
      coin_q       <= coin_sense;
      vend_motor_q <= vend_motor_d;
      eject1_q     <= eject1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
`ifdef REFUND_DISPENSER_COIN5_EN
      den5_q       <= den5_d;
      eject5_q     <= eject5_d;
`endif
    end
  end

  assign vend_motor = vend_motor_q;
  assign eject1     = eject1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign owed       = rem_q;

endmodule

// File: tb/tb_refund_dispenser.sv
// Randomized bench for refund_dispenser: hopper model drives coin_sense, and a
// greedy coin-change model predicts ejects, balance trace and the done/fault outcome.
module tb_refund_dispenser;

  localparam int unsigned P = 4;
  localparam int unsigned T = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] refund;
  logic [3:0] push;
  logic       coin_sense;
  logic       empty5;
  logic       empty1;
  logic [3:0] vend_motor;
  logic       eject5;
  logic       eject1;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] owed;

  always #5 clk = ~clk;

  refund_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .refund(refund), .push(push),
    .coin_sense(coin_sense), .empty5(empty5), .empty1(empty1),
    .vend_motor(vend_motor), .eject5(eject5), .eject1(eject1),
    .busy(busy), .done(done), .fault(fault), .owed(owed)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state
  int cyc = 0;
  int ej_log[$];
  int owed_log[$];
  int done_cnt, done_cyc, vend_cyc, vend_bad, width_bad, overlap_bad, busy_cnt;
  int fault_cyc, last_ej_cyc, ej_w;
  logic [1:0] prev_ej = 2'b00;
  logic       prev_fault = 1'b0;
  logic [3:0] prev_owed = 4'd0;
  logic [3:0] exp_push = 4'd0;

  // Hopper model state
  int drop_cd = 0, hi_cnt = 0, ej_idx = 0, fail_at = -1, hop_delay = 0;

  // One clock: sample outputs on the falling edge, then update the hopper drive
  task automatic step();
    logic [1:0] ej;
    int nz;
    @(negedge clk);
    cyc++;
    ej = {eject5, eject1};
    nz = int'(vend_motor != 4'd0) + int'(eject5) + int'(eject1);
    if (nz > 1) overlap_bad++;
    if (vend_motor != 4'd0) begin
      vend_cyc++;
      if (vend_motor != exp_push) vend_bad++;
    end
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (fault && !prev_fault) fault_cyc = cyc;
    prev_fault = fault;
    if (owed != prev_owed) owed_log.push_back(int'(owed));
    prev_owed = owed;
    if (ej != 2'b00) ej_w++;
    else if (prev_ej != 2'b00) begin
      if (ej_w != int'(P)) width_bad++;
      ej_w = 0;
    end
    if (ej != 2'b00 && prev_ej == 2'b00) begin
      ej_log.push_back(eject5 ? 5 : 1);
      last_ej_cyc = cyc;
      if (ej_idx != fail_at) drop_cd = (hop_delay != 0) ? hop_delay : int'($urandom_range(8, 2));
      ej_idx++;
    end
    prev_ej = ej;
    if (drop_cd > 0) begin
      drop_cd--;
      if (drop_cd == 0) hi_cnt = int'($urandom_range(2, 1));
    end
    if (hi_cnt > 0) begin coin_sense = 1'b1; hi_cnt--; end
    else coin_sense = 1'b0;
  endtask

  task automatic clear_logs();
    ej_log.delete();
    owed_log.delete();
    done_cnt = 0; done_cyc = -1; vend_cyc = 0; vend_bad = 0; width_bad = 0;
    overlap_bad = 0; busy_cnt = 0; fault_cyc = -1; last_ej_cyc = -1; ej_w = 0;
    drop_cd = 0; hi_cnt = 0; ej_idx = 0;
  endtask

  task automatic run_txn(input string name, input int refund_v, input int push_v,
                         input bit e5, input bit e1, input int fail_v, input int delay_v);
    int rem, d, k, guard, start_cyc, n;
    int exp_ej[$];
    int exp_tr[$];
    bit exp_fault, exp_dead;
    // Greedy change-making with static tube state and an optional dead coin
    rem = refund_v; exp_tr.push_back(rem); exp_fault = 0; exp_dead = 0; k = 0;
    while (rem != 0) begin
      d = 0;
`ifdef REFUND_DISPENSER_COIN5_EN
      if (rem >= 5 && !e5) d = 5;
      else
`endif
      if (!e1) d = 1;
      if (d == 0) begin exp_fault = 1; break; end
      exp_ej.push_back(d);
      if (k == fail_v) begin exp_fault = 1; exp_dead = 1; break; end
      rem -= d;
      exp_tr.push_back(rem);
      k++;
    end

    clear_logs();
    hop_delay = delay_v; fail_at = fail_v;
    refund = 4'(refund_v); push = 4'(push_v); empty5 = e5; empty1 = e1; start = 1'b1;
    exp_push = 4'(push_v);
    step();
    start = 1'b0; refund = 4'($urandom); push = 4'($urandom);
    start_cyc = cyc;
    check({name, ":fault_clr"}, fault, 0);
    check({name, ":busy"}, busy, 1);
    owed_log.delete(); owed_log.push_back(int'(owed)); prev_owed = owed;
    guard = 0;
    while (busy === 1'b1 && guard < 4000) begin step(); guard++; end
    check({name, ":idle"}, busy, 0);
    step(); step();

    check({name, ":n_ej"}, ej_log.size(), exp_ej.size());
    n = (ej_log.size() < exp_ej.size()) ? ej_log.size() : exp_ej.size();
    for (int i = 0; i < n; i++) check({name, ":ej_denom"}, ej_log[i], exp_ej[i]);
    check({name, ":n_owed"}, owed_log.size(), exp_tr.size());
    n = (owed_log.size() < exp_tr.size()) ? owed_log.size() : exp_tr.size();
    for (int i = 0; i < n; i++) check({name, ":owed_seq"}, owed_log[i], exp_tr[i]);
    check({name, ":done_cnt"}, done_cnt, exp_fault ? 0 : 1);
    check({name, ":fault"}, fault, exp_fault);
    check({name, ":owed_final"}, owed, exp_tr[exp_tr.size()-1]);
    check({name, ":vend_cycles"}, vend_cyc, (push_v != 0) ? P : 0);
    check({name, ":vend_value"}, vend_bad, 0);
    check({name, ":eject_width"}, width_bad, 0);
    check({name, ":overlap"}, overlap_bad, 0);
    if (!exp_fault) check({name, ":done_last_busy"}, done_cyc, start_cyc + busy_cnt - 1);
    if (refund_v == 0) check({name, ":busy_len"}, busy_cnt, ((push_v != 0) ? P : 0) + 2);
    if (exp_dead) check({name, ":timeout_len"}, fault_cyc - last_ej_cyc, P + T);
  endtask

  initial begin
    int pv, fv;
    rst = 1'b1; start = 1'b0; refund = '0; push = '0;
    coin_sense = 1'b0; empty5 = 1'b0; empty1 = 1'b0;
    clear_logs();
    step(); step();
    check("rst:vend_motor", vend_motor, 0);
    check("rst:eject5", eject5, 0);
    check("rst:eject1", eject1, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:fault", fault, 0);
    check("rst:owed", owed, 0);
    rst = 1'b0;
    step();

    run_txn("vend_only", 0, 2, 0, 0, -1, 3);
    run_txn("r12", 12, 0, 0, 0, -1, 3);
    run_txn("r7_empty5", 7, 0, 1, 0, -1, 0);
    run_txn("timeout", 3, 0, 0, 0, 0, 3);
    run_txn("after_timeout", 0, 0, 0, 0, -1, 0);
    run_txn("empty1", 2, 0, 0, 1, -1, 0);
    run_txn("r15_p8", 15, 8, 0, 0, -1, 0);

    // Reset while waiting on a dead sensor; a start while busy is ignored
    clear_logs();
    fail_at = 0; hop_delay = 3;
    refund = 4'd3; push = 4'd0; empty5 = 1'b0; empty1 = 1'b0; start = 1'b1; exp_push = 4'd0;
    step();
    start = 1'b0;
    repeat (P + 20) step();
    check("midwait:owed", owed, 3);
    start = 1'b1; refund = 4'd9; push = 4'b0100;
    step();
    start = 1'b0;
    step();
    check("busy_start:owed", owed, 3);
    check("busy_start:vend_motor", vend_motor, 0);
    check("busy_start:busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst:vend_motor", vend_motor, 0);
    check("async_rst:eject1", eject1, 0);
    check("async_rst:eject5", eject5, 0);
    check("async_rst:busy", busy, 0);
    check("async_rst:done", done, 0);
    check("async_rst:fault", fault, 0);
    check("async_rst:owed", owed, 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    check("post_rst:busy", busy, 0);
    check("post_rst:owed", owed, 0);
    check("post_rst:eject1", eject1, 0);
    prev_ej = 2'b00;

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(4, 0))
        0: pv = 0;
        1: pv = 1;
        2: pv = 2;
        3: pv = 4;
        default: pv = 8;
      endcase
      fv = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      run_txn("rand", int'($urandom_range(15, 0)), pv,
              $urandom_range(3, 0) == 0, $urandom_range(5, 0) == 0, fv, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
